axi4_mem_responder: RTL and testbench

- Synthesizable AXI4 subordinate (responder) with on-chip memory.
- Answers the AR/R and AW/W/B traffic issued by the kernel's AXI read and write masters.
- Used in kernel-level simulation and on-FPGA loopback in place of DDR, so the TyBEC datapath can run against a known memory image.
- Read and write channels run as independent engines sharing one true-dual-port-style memory array.

---
 rtl/axi4_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_axi4_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_responder.sv
// rtl/axi4_mem_responder.sv - AXI4 responder backed by on-chip memory; optional protocol checker under AXI4_MEM_RESPONDER_CHECK_EN
module axi4_mem_responder #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast
`ifdef AXI4_MEM_RESPONDER_CHECK_EN
    ,
    output logic                            err_sticky
`endif
);
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int BO = $clog2(SW);
    localparam int IW = $clog2(C_MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH];

    logic                          active_q;
    w_state_t                      w_state_q, w_state_d;
    logic [IW-1:0]                 w_idx_q, w_idx_d;
    logic [7:0]                    w_len_q, w_len_d;
    logic [7:0]                    w_cnt_q, w_cnt_d;
    r_state_t                      r_state_q, r_state_d;
    logic [IW-1:0]                 r_idx_q, r_idx_d;
    logic [7:0]                    r_len_q, r_len_d;
    logic [7:0]                    r_cnt_q, r_cnt_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;

    logic w_beat, w_last_beat, r_last_beat;
    logic unused_inputs;

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign r_last_beat = (r_cnt_q == r_len_q);
    assign w_beat      = (w_state_q == W_DATA) && s_axi_wvalid;

    // Ready outputs stay low while in reset and for the cycle it is released.
    assign s_axi_awready = active_q && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_arready = active_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rlast   = (r_state_q == R_DATA) && r_last_beat;
    assign s_axi_rdata   = rdata_q;

    // Address bits outside the word index and wlast only matter to the checker.
    assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast};

    // Marks the first cycle after reset release so handshakes start one cycle later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) active_q <= 1'b0;
        else          active_q <= 1'b1;
    end

    // Write engine next state: beat count alone terminates the burst.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid && active_q) begin
                w_idx_d   = s_axi_awaddr[BO +: IW];
                w_len_d   = s_axi_awlen;
                w_cnt_d   = '0;
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi_wvalid) begin
                w_idx_d = w_idx_q + 1'b1;
                w_cnt_d = w_cnt_q + 1'b1;
                if (w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write engine state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
        end
    end

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge aclk) begin
        if (w_beat) begin
            for (int b = 0; b < SW; b++) begin
                if (s_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Read engine next state: fetch, present, then fetch the next word or finish.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid && active_q) begin
                r_idx_d   = s_axi_araddr[BO +: IW];
                r_len_d   = s_axi_arlen;
                r_cnt_d   = '0;
                r_state_d = R_FETCH;
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: if (s_axi_rready) begin
                if (r_last_beat) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_idx_d   = r_idx_q + 1'b1;
                    r_cnt_d   = r_cnt_q + 1'b1;
                    r_state_d = R_FETCH;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read engine state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Read data register; sampling the array before the same-edge write gives read-first collisions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                    rdata_q <= '0;
        else if (r_state_q == R_FETCH)   rdata_q <= mem_q[r_idx_q];
    end

`ifdef AXI4_MEM_RESPONDER_CHECK_EN
    logic err_q, err_d;

    // Flags wlast disagreeing with the beat count and unaligned burst addresses.
    always_comb begin
        err_d = err_q;
        if (w_beat && (s_axi_wlast != w_last_beat))                           err_d = 1'b1;
        if (s_axi_awvalid && s_axi_awready && (s_axi_awaddr[BO-1:0] != '0))   err_d = 1'b1;
        if (s_axi_arvalid && s_axi_arready && (s_axi_araddr[BO-1:0] != '0))   err_d = 1'b1;
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb/tb_axi4_mem_responder.sv - scoreboard bench for axi4_mem_responder
module tb_axi4_mem_responder;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_axi_awvalid = 1'b0, s_axi_awready;
    logic [63:0]  s_axi_awaddr = '0;
    logic [7:0]   s_axi_awlen = '0;
    logic         s_axi_wvalid = 1'b0, s_axi_wready;
    logic [511:0] s_axi_wdata = '0;
    logic [63:0]  s_axi_wstrb = '0;
    logic         s_axi_wlast = 1'b0;
    logic         s_axi_bvalid, s_axi_bready = 1'b0;
    logic         s_axi_arvalid = 1'b0, s_axi_arready;
    logic [63:0]  s_axi_araddr = '0;
    logic [7:0]   s_axi_arlen = '0;
    logic         s_axi_rvalid, s_axi_rready = 1'b0;
    logic [511:0] s_axi_rdata;
    logic         s_axi_rlast;
`ifdef AXI4_MEM_RESPONDER_CHECK_EN
    logic         err_sticky;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [511:0] model_mem [1024];
    logic [511:0] wdata_src_q [$];
    logic [511:0] exp_data_q [$];
    logic         exp_last_q [$];
    logic [511:0] got_data_q [$];
    logic         got_last_q [$];

    always #5 aclk = ~aclk;

    axi4_mem_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast)
`ifdef AXI4_MEM_RESPONDER_CHECK_EN
        , .err_sticky(err_sticky)
`endif
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic note_timeout(input string what);
        total_cnt++;
        $display("FAIL timeout_%s actual=no_handshake required=handshake", what);
    endtask

    // Write burst; data comes from wdata_src_q, model updated per beat.
    task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [63:0] strb,
                             input int bad_last_beat, input int b_hold, output int b_seen, output bit hold_ok);
        int idx, to;
        logic [511:0] d;
        idx = int'(addr[6 +: 10]);
        hold_ok = 1'b1;
        b_seen = 0;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        to = 0;
        while (s_axi_awready !== 1'b1 && to < 50) begin tick(); to++; end
        if (to >= 50) note_timeout("aw");
        tick();
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            d = wdata_src_q.pop_front();
            s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = strb;
            s_axi_wlast = (bad_last_beat >= 0) ? (i == bad_last_beat) : (i == int'(len));
            to = 0;
            while (s_axi_wready !== 1'b1 && to < 50) begin tick(); to++; end
            if (to >= 50) note_timeout("w");
            tick();
            for (int b = 0; b < 64; b++) if (strb[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
            idx = (idx + 1) % 1024;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        to = 0;
        while (s_axi_bvalid !== 1'b1 && to < 50) begin tick(); to++; end
        if (to >= 50) note_timeout("b");
        for (int k = 0; k < b_hold; k++) begin
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) hold_ok = 1'b0;
            tick();
        end
        if (s_axi_bvalid === 1'b1) b_seen++;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (s_axi_bvalid === 1'b1) b_seen++;
            tick();
        end
    endtask

    // Read burst; expected words pushed from the model at issue, beats collected as they arrive.
    task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input int stall, output bit hold_ok);
        int idx, to, beats;
        logic [511:0] r0;
        logic         l0;
        idx = int'(addr[6 +: 10]);
        hold_ok = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            exp_data_q.push_back(model_mem[(idx + i) % 1024]);
            exp_last_q.push_back(i == int'(len));
        end
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        to = 0;
        while (s_axi_arready !== 1'b1 && to < 50) begin tick(); to++; end
        if (to >= 50) note_timeout("ar");
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_rready = (stall == 0);
        beats = 0; to = 0;
        while (beats <= int'(len) && to < 600) begin
            if (s_axi_rvalid === 1'b1) begin
                if (s_axi_rready !== 1'b1) begin
                    r0 = s_axi_rdata; l0 = s_axi_rlast;
                    for (int k = 0; k < stall; k++) begin
                        tick();
                        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== r0 || s_axi_rlast !== l0) hold_ok = 1'b0;
                    end
                    s_axi_rready = 1'b1;
                end
                got_data_q.push_back(s_axi_rdata);
                got_last_q.push_back(s_axi_rlast);
                beats++;
            end
            tick();
            to++;
        end
        if (beats <= int'(len)) note_timeout("r");
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b0;
        repeat (3) tick();
        total_cnt++; if (s_axi_arready !== 1'b0) $display("FAIL reset_arready actual=%b required=0", s_axi_arready); else pass_cnt++;
        total_cnt++; if (s_axi_awready !== 1'b0) $display("FAIL reset_awready actual=%b required=0", s_axi_awready); else pass_cnt++;
        total_cnt++; if (s_axi_rvalid !== 1'b0) $display("FAIL reset_rvalid actual=%b required=0", s_axi_rvalid); else pass_cnt++;
        total_cnt++; if (s_axi_bvalid !== 1'b0) $display("FAIL reset_bvalid actual=%b required=0", s_axi_bvalid); else pass_cnt++;
        total_cnt++; if (s_axi_rlast !== 1'b0) $display("FAIL reset_rlast actual=%b required=0", s_axi_rlast); else pass_cnt++;
        total_cnt++; if (s_axi_rdata !== 512'h0) $display("FAIL reset_rdata actual=%h required=0", s_axi_rdata); else pass_cnt++;
        s_axi_arvalid = 1'b0;
        aresetn = 1'b1;
        tick();
        total_cnt++; if (s_axi_awready !== 1'b1) $display("FAIL release_awready actual=%b required=1", s_axi_awready); else pass_cnt++;
        total_cnt++; if (s_axi_arready !== 1'b1) $display("FAIL release_arready actual=%b required=1", s_axi_arready); else pass_cnt++;
    endtask

    task automatic compare_reads_inline_write_read();
    endtask

    task automatic test_write_read();
        int bs; bit ok; logic [511:0] ed, gd; logic el, gl;
        for (int i = 1; i <= 4; i++) wdata_src_q.push_back(512'(8'h11 * i));
        axi_write(64'h0, 8'd3, {64{1'b1}}, -1, 0, bs, ok);
        total_cnt++; if (bs !== 1) $display("FAIL wr_bcount actual=%0d required=1", bs); else pass_cnt++;
        axi_read(64'h0, 8'd3, 0, ok);
        total_cnt++; if (got_data_q.size() !== exp_data_q.size()) $display("FAIL wr_rd_beats actual=%0d required=%0d", got_data_q.size(), exp_data_q.size()); else pass_cnt++;
        while (exp_data_q.size() > 0 && got_data_q.size() > 0) begin
            ed = exp_data_q.pop_front(); el = exp_last_q.pop_front();
            gd = got_data_q.pop_front(); gl = got_last_q.pop_front();
            total_cnt++; if (gd !== ed) $display("FAIL wr_rd_data actual=%h required=%h", gd, ed); else pass_cnt++;
            total_cnt++; if (gl !== el) $display("FAIL wr_rd_rlast actual=%b required=%b", gl, el); else pass_cnt++;
        end
        exp_data_q.delete(); exp_last_q.delete(); got_data_q.delete(); got_last_q.delete();
    endtask

    task automatic test_strobe();
        int bs; bit ok; logic [511:0] ed, gd; logic el, gl;
        wdata_src_q.push_back({64{8'hFF}});
        axi_write(64'h140, 8'd0, {64{1'b1}}, -1, 0, bs, ok);
        wdata_src_q.push_back(512'h0);
        axi_write(64'h140, 8'd0, 64'h1, -1, 0, bs, ok);
        axi_read(64'h140, 8'd0, 0, ok);
        total_cnt++; if (got_data_q.size() !== 1) $display("FAIL strb_beats actual=%0d required=1", got_data_q.size()); else pass_cnt++;
        while (exp_data_q.size() > 0 && got_data_q.size() > 0) begin
            ed = exp_data_q.pop_front(); el = exp_last_q.pop_front();
            gd = got_data_q.pop_front(); gl = got_last_q.pop_front();
            total_cnt++; if (gd !== {{63{8'hFF}}, 8'h00}) $display("FAIL strb_data actual=%h required=%h", gd, {{63{8'hFF}}, 8'h00}); else pass_cnt++;
            total_cnt++; if (gd !== ed) $display("FAIL strb_model actual=%h required=%h", gd, ed); else pass_cnt++;
            total_cnt++; if (gl !== el) $display("FAIL strb_rlast actual=%b required=%b", gl, el); else pass_cnt++;
        end
        exp_data_q.delete(); exp_last_q.delete(); got_data_q.delete(); got_last_q.delete();
    endtask

    task automatic test_wrap();
        int bs; bit ok; logic [511:0] ed, gd; logic el, gl;
        wdata_src_q.push_back({16{32'hA5A5_0001}});
        wdata_src_q.push_back({16{32'h5A5A_0002}});
        axi_write(64'(1023 * 64), 8'd1, {64{1'b1}}, -1, 0, bs, ok);
        axi_read(64'(1023 * 64), 8'd1, 0, ok);
        axi_read(64'h0, 8'd0, 0, ok);
        total_cnt++; if (got_data_q.size() !== 3) $display("FAIL wrap_beats actual=%0d required=3", got_data_q.size()); else pass_cnt++;
        while (exp_data_q.size() > 0 && got_data_q.size() > 0) begin
            ed = exp_data_q.pop_front(); el = exp_last_q.pop_front();
            gd = got_data_q.pop_front(); gl = got_last_q.pop_front();
            total_cnt++; if (gd !== ed) $display("FAIL wrap_data actual=%h required=%h", gd, ed); else pass_cnt++;
            total_cnt++; if (gl !== el) $display("FAIL wrap_rlast actual=%b required=%b", gl, el); else pass_cnt++;
        end
        exp_data_q.delete(); exp_last_q.delete(); got_data_q.delete(); got_last_q.delete();
    endtask

    task automatic test_backpressure();
        int bs; bit ok; logic [511:0] ed, gd; logic el, gl;
        wdata_src_q.push_back({8{64'hDEAD_BEEF_0000_0010}});
        wdata_src_q.push_back({8{64'hCAFE_F00D_0000_0011}});
        axi_write(64'(10 * 64), 8'd1, {64{1'b1}}, -1, 3, bs, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL b_hold actual=%b required=1", ok); else pass_cnt++;
        total_cnt++; if (bs !== 1) $display("FAIL b_hold_bcount actual=%0d required=1", bs); else pass_cnt++;
        axi_read(64'(10 * 64), 8'd1, 5, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL r_hold actual=%b required=1", ok); else pass_cnt++;
        total_cnt++; if (got_data_q.size() !== 2) $display("FAIL bp_beats actual=%0d required=2", got_data_q.size()); else pass_cnt++;
        while (exp_data_q.size() > 0 && got_data_q.size() > 0) begin
            ed = exp_data_q.pop_front(); el = exp_last_q.pop_front();
            gd = got_data_q.pop_front(); gl = got_last_q.pop_front();
            total_cnt++; if (gd !== ed) $display("FAIL bp_data actual=%h required=%h", gd, ed); else pass_cnt++;
            total_cnt++; if (gl !== el) $display("FAIL bp_rlast actual=%b required=%b", gl, el); else pass_cnt++;
        end
        exp_data_q.delete(); exp_last_q.delete(); got_data_q.delete(); got_last_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int rseen, bseen, to;
        s_axi_araddr = 64'h0; s_axi_arlen = 8'd3; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 64'(200 * 64); s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
        to = 0;
        while ((s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1) && to < 50) begin tick(); to++; end
        if (to >= 50) note_timeout("mid_addr");
        tick();
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 512'h77; s_axi_wstrb = {64{1'b1}};
        tick();
        s_axi_wvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        rseen = 0; bseen = 0;
        repeat (8) begin
            tick();
            if (s_axi_rvalid === 1'b1) rseen++;
            if (s_axi_bvalid === 1'b1) bseen++;
        end
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        total_cnt++; if (rseen !== 0) $display("FAIL mid_reset_r actual=%0d required=0", rseen); else pass_cnt++;
        total_cnt++; if (bseen !== 0) $display("FAIL mid_reset_b actual=%0d required=0", bseen); else pass_cnt++;
    endtask

`ifdef AXI4_MEM_RESPONDER_CHECK_EN
    task automatic test_checker();
        int bs; bit ok; logic [511:0] ed, gd; logic el, gl;
        total_cnt++; if (err_sticky !== 1'b0) $display("FAIL chk_clean actual=%b required=0", err_sticky); else pass_cnt++;
        for (int i = 0; i < 4; i++) wdata_src_q.push_back(512'(32'h0C0C_0000 + i));
        axi_write(64'(300 * 64), 8'd3, {64{1'b1}}, 1, 0, bs, ok);
        total_cnt++; if (err_sticky !== 1'b1) $display("FAIL chk_err actual=%b required=1", err_sticky); else pass_cnt++;
        total_cnt++; if (bs !== 1) $display("FAIL chk_bcount actual=%0d required=1", bs); else pass_cnt++;
        axi_read(64'(300 * 64), 8'd3, 0, ok);
        total_cnt++; if (got_data_q.size() !== 4) $display("FAIL chk_beats actual=%0d required=4", got_data_q.size()); else pass_cnt++;
        while (exp_data_q.size() > 0 && got_data_q.size() > 0) begin
            ed = exp_data_q.pop_front(); el = exp_last_q.pop_front();
            gd = got_data_q.pop_front(); gl = got_last_q.pop_front();
            total_cnt++; if (gd !== ed) $display("FAIL chk_data actual=%h required=%h", gd, ed); else pass_cnt++;
            total_cnt++; if (gl !== el) $display("FAIL chk_rlast actual=%b required=%b", gl, el); else pass_cnt++;
        end
        exp_data_q.delete(); exp_last_q.delete(); got_data_q.delete(); got_last_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
`ifdef AXI4_MEM_RESPONDER_CHECK_EN
        test_checker();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
